out_display_driver: RTL and testbench

Consumer end of the CPU's output-register path: the CPU performs an OUT (doOut), and the resulting byte and strobe feed this block. Each captured byte is converted to three BCD digits with an iterative double-dabble engine (8 cycles). The digits are driven onto a 3-digit multiplexed 7-segment display with leading-zero blanking. A one-entry pending buffer absorbs an OUT that arrives during a conversion.

---
 rtl/outdisp_pkg.sv | 42 ++++
 rtl/out_display_driver_dd_bcd8.sv | 66 ++++++
 rtl/out_display_driver.sv | 105 ++++++++++
 tb/tb_out_display_driver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/outdisp_pkg.sv
// Shared types, digit indices, 7-segment glyphs and the double-dabble step
// used by the output display driver and its BCD engine.
package outdisp_pkg;

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [1:0] DIG_ONES     = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Glyph for one decimal digit, segments {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg7_of(input logic [3:0] nib);
    case (nib)
      4'd0:    seg7_of = 7'b0111111;
      4'd1:    seg7_of = 7'b0000110;
      4'd2:    seg7_of = 7'b1011011;
      4'd3:    seg7_of = 7'b1001111;
      4'd4:    seg7_of = 7'b1100110;
      4'd5:    seg7_of = 7'b1101101;
      4'd6:    seg7_of = 7'b1111101;
      4'd7:    seg7_of = 7'b0000111;
      4'd8:    seg7_of = 7'b1111111;
      4'd9:    seg7_of = 7'b1101111;
      default: seg7_of = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble iteration on {bcd[11:0], bin[7:0]}: add 3 to every
  // BCD nibble >= 5, then shift the whole register left by one.
  function automatic logic [19:0] dd_step(input logic [19:0] sr);
    logic [19:0] adj;
    adj = sr;
    for (int i = 0; i < 3; i++) begin
      if (adj[8+4*i +: 4] >= 4'd5)
        adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
    end
    dd_step = {adj[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/out_display_driver_dd_bcd8.sv
// Iterative 8-bit binary to 3-digit BCD converter (double dabble).
// A start in IDLE loads the operand; eight CONV edges later the result is
// presented on bcd together with a one-cycle done, and the engine is idle.
module dd_bcd8
  import outdisp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  state_t      state, state_next;
  logic [2:0]  cnt, cnt_next;
  logic [19:0] sr, sr_next, shifted;

  assign shifted = dd_step(sr);
  assign busy    = (state == CONV);
  // The result is taken from the final shift so it is ready on the 8th edge.
  assign bcd     = shifted[19:8];

  // State, iteration counter and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      sr    <= 20'd0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state <= state_next;
      cnt   <= cnt_next;
      sr    <= sr_next;
    end
  end

  // Next-state logic: load on start, iterate in CONV, finish after 8 steps.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_next = state;
    cnt_next   = cnt;
    sr_next    = sr;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sr_next    = {12'd0, bin};
          cnt_next   = 3'd0;
          state_next = CONV;
        end
      end
      CONV: begin
        sr_next  = shifted;
        cnt_next = cnt + 3'd1;
        if (cnt == 3'd7) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/out_display_driver.sv
// Output-register display driver: captures OUT bytes, converts them to BCD,
// and scans three multiplexed 7-segment digits with leading-zero blanking.
// A one-entry pending buffer holds a byte that arrives during a conversion.
module out_display_driver
  import outdisp_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        out_strobe,
  input  logic [7:0]  out_data,
  output logic        busy,
  output logic        overrun,
  output logic [11:0] bcd_value,
  output logic [6:0]  seg,
  output logic [2:0]  dig_en
);

  localparam int PW = $clog2(SCAN_DIV);

  logic          pending_valid;
  logic [7:0]    pending_data;
  logic          start;
  logic [7:0]    start_bin;
  logic          done;
  logic [11:0]   conv_bcd;
  logic [PW-1:0] presc;
  logic [1:0]    dig_idx;
  logic [3:0]    digit;
  logic          blank;

  // A waiting pending byte always wins over a fresh strobe.
  assign start     = !busy && (pending_valid || out_strobe);
  assign start_bin = pending_valid ? pending_data : out_data;

  dd_bcd8 u_dd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (start_bin),
    .busy  (busy),
    .done  (done),
    .bcd   (conv_bcd)
  );

  // Pending buffer: park strobes that cannot start now; flag lost bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_valid <= 1'b0;
      pending_data  <= 8'd0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (out_strobe && (busy || pending_valid)) begin
        pending_data  <= out_data;
        pending_valid <= 1'b1;
        overrun       <= busy && pending_valid;
      end else if (start && pending_valid) begin
        pending_valid <= 1'b0;
      end
    end
  end

  // Displayed value updates only when a conversion completes.
  always_ff @(posedge clk) begin
    if (reset)     bcd_value <= 12'd0;
    else if (done) bcd_value <= conv_bcd;
  end

  // Scan prescaler and digit index: each digit lit for SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      dig_idx <= DIG_ONES;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc   <= '0;
      dig_idx <= (dig_idx == DIG_HUNDREDS) ? DIG_ONES : dig_idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Digit select, leading-zero blanking and segment decode.
  always_comb begin
    digit  = bcd_value[3:0];
    blank  = 1'b0;
    dig_en = 3'b001;
    case (dig_idx)
      DIG_TENS: begin
        digit  = bcd_value[7:4];
        blank  = (bcd_value[11:8] == 4'd0) && (bcd_value[7:4] == 4'd0);
        dig_en = 3'b010;
      end
      DIG_HUNDREDS: begin
        digit  = bcd_value[11:8];
        blank  = (bcd_value[11:8] == 4'd0);
        dig_en = 3'b100;
      end
      default: ;
    endcase
    seg = blank ? SEG_BLANK : seg7_of(digit);
  end

endmodule

// File: tb/tb_out_display_driver.sv
// Directed bench for out_display_driver. Expected display values are queued
// as strobes are issued; a monitor pops and compares on each completion
// (busy falling outside reset).
module tb_out_display_driver;

  localparam int SCAN_DIV = 4;

  localparam logic [6:0] G0 = 7'b0111111;
  localparam logic [6:0] G2 = 7'b1011011;
  localparam logic [6:0] G5 = 7'b1101101;
  localparam logic [6:0] G7 = 7'b0000111;
  localparam logic [6:0] GB = 7'b0000000;

  logic        clk;
  logic        reset;
  logic        out_strobe;
  logic [7:0]  out_data;
  logic        busy;
  logic        overrun;
  logic [11:0] bcd_value;
  logic [6:0]  seg;
  logic [2:0]  dig_en;

  int total = 0;
  int bad   = 0;
  int ov_count = 0;
  logic [11:0] exp_q[$];

  out_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .out_strobe (out_strobe),
    .out_data   (out_data),
    .busy       (busy),
    .overrun    (overrun),
    .bcd_value  (bcd_value),
    .seg        (seg),
    .dig_en     (dig_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a completed conversion is busy falling while not in reset.
  initial begin
    logic busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_prev = 1'b0;
      end else begin
        if (busy_prev && !busy) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_update: got %0h, expected no update", bcd_value);
          end else begin
            check("bcd_value", {20'd0, bcd_value}, {20'd0, exp_q.pop_front()});
          end
        end
        busy_prev = busy;
        if (overrun) ov_count++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d);
    out_strobe = 1'b1;
    out_data   = d;
    tick();
    out_strobe = 1'b0;
    out_data   = 8'd0;
  endtask

  // Idle means busy low on two consecutive samples (a pending byte would
  // restart the engine one cycle after completion).
  task automatic wait_idle();
    int zeros = 0;
    int n = 0;
    while (zeros < 2 && n < 100) begin
      if (!busy) zeros++;
      else       zeros = 0;
      tick();
      n++;
    end
    check("wait_idle_in_budget", {31'd0, n < 100}, 32'd1);
  endtask

  task automatic check_scan(input logic [6:0] s_ones, input logic [6:0] s_tens,
                            input logic [6:0] s_hund);
    int n = 0;
    while (dig_en !== 3'b001 && n < 20) begin
      tick();
      n++;
    end
    check("scan_sync", {31'd0, n < 20}, 32'd1);
    check("dig_en_ones", {29'd0, dig_en}, 32'b001);
    check("seg_ones", {25'd0, seg}, {25'd0, s_ones});
    repeat (SCAN_DIV) tick();
    check("dig_en_tens", {29'd0, dig_en}, 32'b010);
    check("seg_tens", {25'd0, seg}, {25'd0, s_tens});
    repeat (SCAN_DIV) tick();
    check("dig_en_hund", {29'd0, dig_en}, 32'b100);
    check("seg_hund", {25'd0, seg}, {25'd0, s_hund});
    repeat (SCAN_DIV) tick();
    check("dig_en_wrap", {29'd0, dig_en}, 32'b001);
  endtask

  initial begin
    int busy_cycles;
    int ov_before;

    reset      = 1'b1;
    out_strobe = 1'b0;
    out_data   = 8'd0;
    repeat (2) tick();
    check("rst_bcd_value", {20'd0, bcd_value}, 32'h000);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_dig_en", {29'd0, dig_en}, 32'b001);
    check("rst_seg", {25'd0, seg}, {25'd0, G0});
    reset = 1'b0;
    tick();

    // 0xFF -> 255, busy for exactly 8 cycles, full scan 5/5/2.
    exp_q.push_back(12'h255);
    strobe(8'hFF);
    busy_cycles = 0;
    repeat (12) begin
      if (busy) busy_cycles++;
      tick();
    end
    check("busy_cycles_ff", busy_cycles, 8);
    check_scan(G5, G5, G2);

    // 0x07 -> 007, tens and hundreds blanked.
    exp_q.push_back(12'h007);
    strobe(8'h07);
    wait_idle();
    check_scan(G7, GB, GB);

    // 0x64 then 0x0A at e3: pending path, no overrun.
    ov_before = ov_count;
    exp_q.push_back(12'h100);
    exp_q.push_back(12'h010);
    strobe(8'h64);
    repeat (2) tick();
    strobe(8'h0A);
    repeat (5) tick();
    check("e8_bcd_100", {20'd0, bcd_value}, 32'h100);
    check("e8_busy_low", {31'd0, busy}, 32'd0);
    tick();
    check("e9_busy_high", {31'd0, busy}, 32'd1);
    repeat (8) tick();
    check("e17_bcd_010", {20'd0, bcd_value}, 32'h010);
    wait_idle();
    check("overrun_none", ov_count - ov_before, 0);

    // 0x01, then 0x02 and 0x03 during CONV: 0x02 lost, one overrun pulse.
    ov_before = ov_count;
    exp_q.push_back(12'h001);
    exp_q.push_back(12'h003);
    strobe(8'h01);
    tick();
    strobe(8'h02);
    check("overrun_first_pending", {31'd0, overrun}, 32'd0);
    tick();
    strobe(8'h03);
    check("overrun_pulse", {31'd0, overrun}, 32'd1);
    wait_idle();
    check("overrun_count", ov_count - ov_before, 1);
    check("final_bcd_003", {20'd0, bcd_value}, 32'h003);

    // 0xC8 aborted by reset at e4: no later update to 200.
    strobe(8'hC8);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("abort_bcd_value", {20'd0, bcd_value}, 32'h000);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_dig_en", {29'd0, dig_en}, 32'b001);
    check("abort_seg", {25'd0, seg}, {25'd0, G0});
    reset = 1'b0;
    repeat (15) tick();
    check("abort_no_update", {20'd0, bcd_value}, 32'h000);
    check("abort_stays_idle", {31'd0, busy}, 32'd0);

    // 0x00 -> only the ones digit lit.
    exp_q.push_back(12'h000);
    strobe(8'h00);
    wait_idle();
    check_scan(G0, GB, GB);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
